// File: rtl/probe_meter_pkg.sv
// Shared types and helpers for the probe_meter window statistics block.
// Full-scale codes and accumulator sizing depend on the sample width.
package probe_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEF_DATA_W   = 12;
    localparam int DEF_WIN_LOG2 = 4;
    localparam int DEF_ACC_W    = DEF_DATA_W + DEF_WIN_LOG2;

    // Largest positive two's complement code for a w-bit sample.
    function automatic logic signed [31:0] fs_max(input int w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    // Most negative two's complement code for a w-bit sample.
    function automatic logic signed [31:0] fs_min(input int w);
        return -(32'sd1 <<< (w - 1));
    endfunction

    // Window sum of 2**win_log2 samples cannot exceed this many bits.
    function automatic int acc_width(input int data_w, input int win_log2);
        return data_w + win_log2;
    endfunction

endpackage

// File: rtl/probe_meter_stats.sv
// Running min/max/sum/over-range datapath for one measurement window.
// The *_nxt outputs already include din, so a caller can capture the final result on the last sample.
module probe_meter_stats
    import probe_meter_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] min_nxt,
    output logic signed [DATA_W-1:0] max_nxt,
    output logic signed [DATA_W-1:0] avg_nxt,
    output logic                     ovr_nxt
);

    localparam int ACC_W = acc_width(DATA_W, WIN_LOG2);
    localparam logic signed [DATA_W-1:0] FS_MAX = DATA_W'(fs_max(DATA_W));
    localparam logic signed [DATA_W-1:0] FS_MIN = DATA_W'(fs_min(DATA_W));

    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  sum_nxt;
    logic signed [DATA_W-1:0] mn;
    logic signed [DATA_W-1:0] mx;
    logic                     ovr;

    always_comb begin
        sum_nxt = sum + $signed({{WIN_LOG2{din[DATA_W-1]}}, din});
        min_nxt = (din < mn) ? din : mn;
        max_nxt = (din > mx) ? din : mx;
        ovr_nxt = ovr | (din == FS_MAX) | (din == FS_MIN);
    end

    // Upper DATA_W bits of the sum are the arithmetic shift by WIN_LOG2: floor toward -inf.
    assign avg_nxt = sum_nxt[ACC_W-1:WIN_LOG2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
            mn  <= '0;
            mx  <= '0;
            ovr <= 1'b0;
        end else if (clr) begin
            sum <= '0;
            mn  <= FS_MAX;
            mx  <= FS_MIN;
            ovr <= 1'b0;
        end else if (en) begin
            sum <= sum_nxt;
            mn  <= min_nxt;
            mx  <= max_nxt;
            ovr <= ovr_nxt;
        end
    end

endmodule

// File: rtl/probe_meter.sv
// Probe read-back meter: reduces a 2**WIN_LOG2 sample window to min/max/avg
// and offers the result on a valid/ready port.
module probe_meter
    import probe_meter_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    output logic              smp_ready,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_min,
    output logic [DATA_W-1:0] res_max,
    output logic [DATA_W-1:0] res_avg,
    output logic              res_ovr
);

    state_t                   state;
    state_t                   state_nxt;
    logic [WIN_LOG2-1:0]      cnt;
    logic                     acc;
    logic                     last;
    logic                     clr;
    logic signed [DATA_W-1:0] min_nxt;
    logic signed [DATA_W-1:0] max_nxt;
    logic signed [DATA_W-1:0] avg_nxt;
    logic                     ovr_nxt;

    assign acc  = smp_valid && (state == ACQ);
    assign last = acc && (cnt == '1);
    // Accumulators sit cleared outside ACQ so every entry into ACQ starts a fresh window.
    assign clr  = (state != ACQ);

    assign smp_ready = (state == ACQ);
    assign busy      = (state != IDLE);
    assign res_valid = (state == HOLD);

    probe_meter_stats #(
        .DATA_W   (DATA_W),
        .WIN_LOG2 (WIN_LOG2)
    ) u_stats (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .en      (acc),
        .din     ($signed(smp_data)),
        .min_nxt (min_nxt),
        .max_nxt (max_nxt),
        .avg_nxt (avg_nxt),
        .ovr_nxt (ovr_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = ACQ;
            ACQ:  if (last) state_nxt = HOLD;
            HOLD: if (res_ready) state_nxt = start ? ACQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (acc)   cnt <= cnt + 1'b1;
    end

    // Result registers capture on the final sample, so res_valid and data align on the first HOLD cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_min <= '0;
            res_max <= '0;
            res_avg <= '0;
            res_ovr <= 1'b0;
        end else if (last) begin
            res_min <= min_nxt;
            res_max <= max_nxt;
            res_avg <= avg_nxt;
            res_ovr <= ovr_nxt;
        end
    end

endmodule
